// File: rtl/tmp_seq.sv
// Control sequencer for the TMPH/TMPL register pair: turns byte-level commands
// into ordered setup/strobe/hold control strobes and a timed address-bus drive.
module tmp_seq #(
    parameter int ADDR_CYCLES = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_op,
    output logic       cmd_ready,
    input  logic       bus_ack,
    output logic       done,
    output logic       err,
    output logic       reg_tmph_data_dir,
    output logic       reg_tmpl_data_dir,
    output logic       reg_tmph_pass_data,
    output logic       reg_tmpl_pass_data,
    output logic       reg_tmph_load,
    output logic       reg_tmpl_load,
    output logic       reg_tmph_out,
    output logic       reg_tmpl_out,
    output logic       reg_tmp_pass_address,
    output logic       reg_tmp_address_dir
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WAIT_ACK, S_STROBE, S_HOLD, S_ADDR, S_DONE
    } state_t;

    localparam logic [2:0] OP_LOAD_L  = 3'd0;
    localparam logic [2:0] OP_LOAD_H  = 3'd1;
    localparam logic [2:0] OP_LOAD_HL = 3'd2;
    localparam logic [2:0] OP_STORE_L = 3'd3;
    localparam logic [2:0] OP_STORE_H = 3'd4;
    localparam logic [2:0] OP_DRIVE   = 3'd5;

    localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] ADDR_LAST = 8'(ADDR_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [2:0] op_reg, op_next;
    logic       sel_reg, sel_next;      // 0 = TMPL, 1 = TMPH
    logic [7:0] cnt_reg, cnt_next;
    logic       err_next;
    logic       cmd_ready_reg, done_reg, err_reg;
    logic       pass_addr_reg, addr_dir_reg;
    logic       store_next, byte_active_next;

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    op_next  = cmd_op;
                    cnt_next = 8'd0;
                    case (cmd_op)
                        OP_LOAD_L, OP_LOAD_HL, OP_STORE_L: begin
                            sel_next   = 1'b0;
                            state_next = S_SETUP;
                        end
                        OP_LOAD_H, OP_STORE_H: begin
                            sel_next   = 1'b1;
                            state_next = S_SETUP;
                        end
                        OP_DRIVE: state_next = S_ADDR;
                        default:  err_next   = 1'b1;
                    endcase
                end
            end
            S_SETUP: begin
                cnt_next   = 8'd0;
                state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // An ack arriving on the terminal count still completes the byte.
                if (bus_ack) begin
                    state_next = (op_reg == OP_STORE_L || op_reg == OP_STORE_H) ? S_HOLD : S_STROBE;
                end else if (cnt_reg == ACK_LAST) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_STROBE: state_next = S_HOLD;
            S_HOLD: begin
                if (op_reg == OP_LOAD_HL && !sel_reg) begin
                    sel_next   = 1'b1;
                    state_next = S_SETUP;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_ADDR: begin
                if (cnt_reg == ADDR_LAST) state_next = S_DONE;
                else                      cnt_next   = cnt_reg + 8'd1;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they line up with it.
    assign store_next       = (op_next == OP_STORE_L) || (op_next == OP_STORE_H);
    assign byte_active_next = (state_next == S_SETUP) || (state_next == S_WAIT_ACK) ||
                              (state_next == S_STROBE) || (state_next == S_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            op_reg        <= 3'd0;
            sel_reg       <= 1'b0;
            cnt_reg       <= 8'd0;
            cmd_ready_reg <= 1'b1;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            pass_addr_reg <= 1'b1;
            addr_dir_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            sel_reg       <= sel_next;
            cnt_reg       <= cnt_next;
            cmd_ready_reg <= (state_next == S_IDLE);
            done_reg      <= (state_next == S_DONE);
            err_reg       <= err_next;
            pass_addr_reg <= (state_next != S_ADDR);
            addr_dir_reg  <= (state_next != S_ADDR);
        end
    end

    logic [1:0] dir_q, pass_q, load_q, out_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_byte
            logic selected;
            logic dir_next, pass_next, load_next, out_next;
            logic dir_reg, pass_reg, load_reg, out_reg;

            assign selected = byte_active_next && (sel_next == 1'(gi));

            always_comb begin
                dir_next  = 1'b1;
                pass_next = 1'b1;
                load_next = 1'b0;
                out_next  = 1'b1;
                if (selected) begin
                    pass_next = 1'b0;
                    if (store_next) begin
                        dir_next = 1'b0;
                        out_next = 1'b0;
                    end else begin
                        load_next = (state_next == S_STROBE);
                    end
                end
                if (state_next == S_ADDR) out_next = 1'b0;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    dir_reg  <= 1'b1;
                    pass_reg <= 1'b1;
                    load_reg <= 1'b0;
                    out_reg  <= 1'b1;
                end else begin
                    dir_reg  <= dir_next;
                    pass_reg <= pass_next;
                    load_reg <= load_next;
                    out_reg  <= out_next;
                end
            end

            assign dir_q[gi]  = dir_reg;
            assign pass_q[gi] = pass_reg;
            assign load_q[gi] = load_reg;
            assign out_q[gi]  = out_reg;
        end
    endgenerate

    assign cmd_ready            = cmd_ready_reg;
    assign done                 = done_reg;
    assign err                  = err_reg;
    assign reg_tmpl_data_dir    = dir_q[0];
    assign reg_tmph_data_dir    = dir_q[1];
    assign reg_tmpl_pass_data   = pass_q[0];
    assign reg_tmph_pass_data   = pass_q[1];
    assign reg_tmpl_load        = load_q[0];
    assign reg_tmph_load        = load_q[1];
    assign reg_tmpl_out         = out_q[0];
    assign reg_tmph_out         = out_q[1];
    assign reg_tmp_pass_address = pass_addr_reg;
    assign reg_tmp_address_dir  = addr_dir_reg;

endmodule

// File: tb/tb_tmp_seq.sv
// Self-checking bench for tmp_seq: per-cycle trace comparison against a phase
// timeline model, plus a TMP register model fed by the generated strobes.
module tb_tmp_seq;
    localparam int ADDR_CYCLES = 2;
    localparam int ACK_TIMEOUT = 16;
    localparam int MAXC        = 64;

    // {cmd_ready, done, err, h_dir, h_pass, h_load, h_out, l_dir, l_pass, l_load, l_out, pass_addr, addr_dir}
    localparam logic [12:0] IDLE_V = 13'b1_0_0_1101_1101_1_1;

    logic clk = 1'b0;
    logic rst, cmd_valid, bus_ack;
    logic [2:0] cmd_op;
    logic cmd_ready, done, err;
    logic reg_tmph_data_dir, reg_tmpl_data_dir, reg_tmph_pass_data, reg_tmpl_pass_data;
    logic reg_tmph_load, reg_tmpl_load, reg_tmph_out, reg_tmpl_out;
    logic reg_tmp_pass_address, reg_tmp_address_dir;

    always #5 clk = ~clk;

    tmp_seq #(.ADDR_CYCLES(ADDR_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .bus_ack(bus_ack), .done(done), .err(err),
        .reg_tmph_data_dir(reg_tmph_data_dir), .reg_tmpl_data_dir(reg_tmpl_data_dir),
        .reg_tmph_pass_data(reg_tmph_pass_data), .reg_tmpl_pass_data(reg_tmpl_pass_data),
        .reg_tmph_load(reg_tmph_load), .reg_tmpl_load(reg_tmpl_load),
        .reg_tmph_out(reg_tmph_out), .reg_tmpl_out(reg_tmpl_out),
        .reg_tmp_pass_address(reg_tmp_pass_address), .reg_tmp_address_dir(reg_tmp_address_dir)
    );

    wire [12:0] obs = {cmd_ready, done, err,
                       reg_tmph_data_dir, reg_tmph_pass_data, reg_tmph_load, reg_tmph_out,
                       reg_tmpl_data_dir, reg_tmpl_pass_data, reg_tmpl_load, reg_tmpl_out,
                       reg_tmp_pass_address, reg_tmp_address_dir};

    // TMP register pair model: captures the data-bus source on the load rising edge
    logic [7:0] tmp_l, tmp_h, src_l, src_h;
    always @(posedge reg_tmpl_load) tmp_l <= src_l;
    always @(posedge reg_tmph_load) tmp_h <= src_h;
    wire [15:0] addr_bus = (!reg_tmp_pass_address && !reg_tmp_address_dir &&
                            !reg_tmph_out && !reg_tmpl_out) ? {tmp_h, tmp_l} : 16'hxxxx;

    int errors = 0;
    int checks = 0;

    logic [12:0] exp_tr   [MAXC];
    bit          exp_addr [MAXC];
    bit          ack_arr  [MAXC];
    int          end_c;
    logic [7:0]  exp_l, exp_h;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [12:0] byte_vec(input int b, input bit store, input bit ld);
        logic [12:0] v;
        int base;
        v     = IDLE_V;
        v[12] = 1'b0;
        base  = (b == 1) ? 6 : 2;
        v[base + 2] = 1'b0;
        if (store) begin
            v[base + 3] = 1'b0;
            v[base]     = 1'b0;
        end else begin
            v[base + 1] = ld;
        end
        return v;
    endfunction

    // Expected trace from the command's phase timeline and the per-cycle ack pattern.
    task automatic build(input int op, input int rst_at);
        int s, w, e, b, nph;
        bit store, timed_out;
        logic [12:0] v;
        for (int c = 0; c < MAXC; c++) begin
            exp_tr[c]   = IDLE_V;
            exp_addr[c] = 1'b0;
        end
        timed_out = 1'b0;
        if (op >= 6) begin
            exp_tr[1][10] = 1'b1;
            end_c = 1;
        end else if (op == 5) begin
            for (int c = 1; c <= ADDR_CYCLES; c++) begin
                v = IDLE_V; v[12] = 0; v[6] = 0; v[2] = 0; v[1] = 0; v[0] = 0;
                exp_tr[c]   = v;
                exp_addr[c] = 1'b1;
            end
            v = IDLE_V; v[12] = 0; v[11] = 1;
            exp_tr[ADDR_CYCLES + 1] = v;
            end_c = ADDR_CYCLES + 1;
        end else begin
            nph   = (op == 2) ? 2 : 1;
            store = (op >= 3);
            s     = 1;
            for (int p = 0; p < nph; p++) begin
                b = (op == 1 || op == 4) ? 1 : ((op == 2) ? p : 0);
                w = -1;
                for (int c = s + 1; c <= s + ACK_TIMEOUT; c++)
                    if (ack_arr[c] && w < 0) w = c;
                if (w < 0) begin
                    for (int c = s; c <= s + ACK_TIMEOUT; c++) exp_tr[c] = byte_vec(b, store, 1'b0);
                    s = s + ACK_TIMEOUT + 1;
                    exp_tr[s][10] = 1'b1;
                    end_c = s;
                    timed_out = 1'b1;
                    break;
                end
                e = store ? w + 1 : w + 2;
                for (int c = s; c <= e; c++) exp_tr[c] = byte_vec(b, store, !store && c == w + 1);
                if (!store && (rst_at == 0 || w + 1 <= rst_at)) begin
                    if (b == 1) exp_h = src_h;
                    else        exp_l = src_l;
                end
                s = e + 1;
            end
            if (!timed_out) begin
                v = IDLE_V; v[12] = 0; v[11] = 1;
                exp_tr[s] = v;
                end_c = s;
            end
        end
        if (rst_at > 0) begin
            for (int c = rst_at + 1; c < MAXC; c++) begin
                exp_tr[c]   = IDLE_V;
                exp_addr[c] = 1'b0;
            end
            end_c = rst_at + 2;
        end
    endtask

    task automatic run_txn(input int op, input int rst_at, input string name);
        build(op, rst_at);
        for (int c = 0; c <= end_c + 1; c++) begin
            @(posedge clk); #1;
            chk($sformatf("%s c%0d", name, c), 32'(obs), 32'(exp_tr[c]));
            if (exp_addr[c]) chk($sformatf("%s addr c%0d", name, c), 32'(addr_bus), {16'h0, exp_h, exp_l});
            rst     = (rst_at > 0) && (c == rst_at || c == rst_at + 1);
            bus_ack = ack_arr[c];
            if (c == 0) begin
                cmd_valid = 1'b1;
                cmd_op    = 3'(op);
            end else if (c < end_c && (rst_at == 0 || c < rst_at)) begin
                // Commands offered while busy must be ignored.
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 3'($urandom_range(0, 7));
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        bus_ack   = 1'b0;
        chk({name, " tmp"}, {16'h0, tmp_h, tmp_l}, {16'h0, exp_h, exp_l});
        $display("txn %-12s op=%0d rst_at=%0d cycles=%0d tmp=%h", name, op, rst_at, end_c, {tmp_h, tmp_l});
    endtask

    task automatic set_ack_from(input int first);
        for (int c = 0; c < MAXC; c++) ack_arr[c] = (first >= 0) && (c >= first);
    endtask

    initial begin
        int mode;
        rst = 1'b1; cmd_valid = 1'b0; bus_ack = 1'b0; cmd_op = 3'd0;
        src_l = 8'h00; src_h = 8'h00; tmp_l = 8'h00; tmp_h = 8'h00;
        exp_l = 8'h00; exp_h = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 32'(obs), 32'(IDLE_V));
        rst = 1'b0;

        src_l = 8'h5A; set_ack_from(0);
        run_txn(0, 0, "load_l");

        src_l = 8'h34; src_h = 8'h12; set_ack_from(0);
        run_txn(2, 0, "load_hl");
        chk("tmp_1234", {16'h0, tmp_h, tmp_l}, 32'h0000_1234);

        set_ack_from(6);
        run_txn(4, 0, "store_h");

        src_l = 8'hEF; src_h = 8'hBE; set_ack_from(0);
        run_txn(2, 0, "load_beef");
        run_txn(5, 0, "drive_addr");

        set_ack_from(-1);
        run_txn(1, 0, "timeout");
        run_txn(7, 0, "illegal");

        src_l = 8'h77; src_h = 8'h88;
        for (int c = 0; c < MAXC; c++) ack_arr[c] = (c <= 2);
        run_txn(2, 7, "reset_mid");

        for (int t = 0; t < 40; t++) begin
            src_l = 8'($urandom);
            src_h = 8'($urandom);
            mode  = $urandom_range(0, 5);
            for (int c = 0; c < MAXC; c++) begin
                case (mode)
                    0:       ack_arr[c] = 1'b1;
                    1, 2:    ack_arr[c] = ($urandom_range(0, 1) == 1);
                    3, 4:    ack_arr[c] = ($urandom_range(0, 7) == 0);
                    default: ack_arr[c] = 1'b0;
                endcase
            end
            run_txn($urandom_range(0, 7), 0, $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
